lockin_result_collector: RTL and testbench
==========================================

# lockin_result_collector

Return path of one NCO channel. Captures lock-in X/Y outputs whenever the channel FSM pulses `XY_ch_acquire`, tags them with the NCO parameters in force at that instant, and writes a 128-bit result word into a dual-clock FIFO (`result_fifo`, 128 bit × 512, show-ahead). The UDP transmitter drains that FIFO in the `clk_udp` domain. The block mirrors the sweep FIFO: `sweep_fifo` carries commands UDP→NCO, and this block carries results NCO→UDP.

## Interface
Parameters:
- `IDX_W`, 16: width of the sample index field.

Ports:
- `clk_50` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `running` in 1: channel FSM running flag.
- `XY_ch_acquire` in 1: one-cycle capture strobe.
- `X_in` in 32: signed lock-in X, valid in the strobe cycle.
- `Y_in` in 32: signed lock-in Y, valid in the strobe cycle.
- `NCO_ch_parameters` in 80: {freq_initial[79:48], freq_mod[47:16], amplitude[15:0]}.
- `clr_fifo_cmd` in 1: `clk_50` pulse that clears the FIFO and status.
- `clk_udp` in 1: read clock.
- `result_rd_udp` in 1: read acknowledge (show-ahead).
- `result_data_udp` out 128: FIFO head word.
- `result_empty_udp` out 1: FIFO empty (`clk_udp` domain).
- `overflow` out 1: sticky, at least one capture was dropped.
- `dropped_count` out 16: number of dropped captures, saturating at 0xFFFF.

## Operation
- Result word:
  - [127:96] = freq_initial + freq_mod, mod 2^32. This is the actual tuning word.
  - [95:64] = X.
  - [63:32] = Y.
  - [31:16] = sample index.
  - [15:0] = amplitude, or the timestamp when the configuration macro is defined (see Configuration).
- States:
  - IDLE: waits for `running` to be 1. On the rising edge of `running`, clears the sample index and timestamp, then moves to ARMED.
  - ARMED: on `XY_ch_acquire`=1 with `running`=1, latches the word into the hold register and moves to WRITE. Falling `running` with no pending word returns to IDLE.
  - WRITE: asserts `wrreq` for exactly one cycle if `wrfull`=0, then returns to ARMED, or to IDLE if `running`=0. If `wrfull`=1, moves to HOLD.
  - HOLD: keeps the word and retries every cycle until `wrfull`=0. After the write, returns to ARMED or IDLE as in WRITE.
- Sample index:
  - Increments on every accepted strobe, including dropped ones, so the host sees gaps.
  - Wraps from 2^IDX_W−1 to 0.
  - The first word of a run carries index 0.
- Strobe while WRITE/HOLD holds a pending word:
  - The new sample is dropped.
  - `overflow` is set to 1.
  - `dropped_count` increments, saturating.
  - The sample index still increments.
- A strobe with `running`=0 is ignored: no index change, no drop count.
- `clr_fifo_cmd`:
  - Drives the FIFO `aclr`.
  - Clears the hold register, `overflow`, `dropped_count` and the sample index.
  - Forces the FSM to IDLE.
  - Has priority over a coincident strobe; the strobe is discarded.

## Timing
- Reset values: `overflow`=0, `dropped_count`=0, FSM=IDLE, index=0, internal `wrreq`=0. `result_empty_udp`=1 once the FIFO is cleared.
- Strobe in cycle T:
  - Hold register loads at the T+1 edge.
  - `wrreq` is high in cycle T+1 when the FIFO is not full.
  - The word is stored at the T+2 edge.
  - `result_empty_udp` falls after the IP synchronizer latency, 3 `clk_udp` cycles or fewer.
- NCO parameters are sampled in the strobe cycle, i.e. the value before the frequency step. The channel FSM pulses 1 cycle before changing the parameters.
- Minimum strobe spacing for lossless capture: 2 cycles when the FIFO is not full.
- Rising and falling `running` edges are detected with a 1-cycle registered copy.
  - A strobe coincident with `running` rising in cycle T is ignored, because the FSM is still in IDLE.
  - A strobe in the last cycle with `running`=1 is captured and written.
- Reset mid-WRITE/HOLD: the pending word is lost and no `wrreq` is issued after reset.

## Configuration
- `LOCKIN_RESULT_TIMESTAMP_EN` defined:
  - A free-running 32-bit `clk_50` counter is cleared on the `running` rising edge.
  - Bits [15:0] of the result word carry counter[15:0] sampled in the strobe cycle.
- Not defined: bits [15:0] carry the amplitude and the counter is not instantiated.

## Test plan
- Lossless capture:
  - Stimulus: `running`=1; 4 strobes spaced 100 cycles; X=0x1,0x2,0x3,0x4; Y=−X; freq_initial=0x1000_0000; freq_mod=0x10 per step.
  - Response: 4 words, indices 0–3, [127:96]=0x1000_0000,…,0x1000_0030, `overflow`=0.
- Full FIFO:
  - Stimulus: fill to 512 words with no reads, then one strobe.
  - Response: the state holds in HOLD.
  - Stimulus: a second strobe 5 cycles later.
  - Response: `overflow`=1 and `dropped_count`=1.
  - Stimulus: one read.
  - Response: the held word is written with index 512 mod 2^16; the next accepted word has index 514.
- Back-to-back strobes:
  - Stimulus: strobes in cycles T and T+1.
  - Response: the second is dropped, `dropped_count`=1, and the next word's index skips by 2.
- Run restart:
  - Stimulus: `running` 1→0→1, then a strobe.
  - Response: index 0. With the macro defined, the timestamp is small, equal to the cycles since the rising edge.
- Clear and reset:
  - Stimulus: `clr_fifo_cmd` coincident with a strobe.
  - Response: `result_empty_udp`=1, counters 0, no word written.
  - Stimulus: `reset` asserted in HOLD.
  - Response: no further `wrreq`.
- Idle strobe:
  - Stimulus: strobe with `running`=0.
  - Response: no FIFO write and no index change.

Source files
------------

// File: rtl/lockin_result_collector.sv
// lockin_result_collector: captures lock-in X/Y on each channel acquire strobe,
// tags the sample with the NCO tuning word, a sample index and either the
// amplitude or a run timestamp, and pushes the 128-bit result into a
// dual-clock show-ahead FIFO drained from the clk_udp domain.
// Optional feature macro: LOCKIN_RESULT_TIMESTAMP_EN (bits [15:0] carry a
// 32-bit run timestamp instead of the amplitude).

module result_fifo (
    input  logic         aclr,
    input  logic         wrclk,
    input  logic         wrreq,
    input  logic [127:0] data,
    output logic         wrfull,
    input  logic         rdclk,
    input  logic         rdreq,
    output logic [127:0] q,
    output logic         rdempty
);
    logic [127:0] mem [0:511];
    logic [9:0]   wbin, wgray, rq1, rq2;
    logic [9:0]   rbin, rgray, wq1, wq2;
    logic [9:0]   wbin_next, rbin_next;

    assign wbin_next = wbin + 10'd1;
    assign rbin_next = rbin + 10'd1;

    // Storage write port
    always_ff @(posedge wrclk) begin
        if (wrreq && !wrfull)
            mem[wbin[8:0]] <= data;
    end

    // Write pointer and read-pointer synchroniser
    always_ff @(posedge wrclk or posedge aclr) begin
        if (aclr) begin
            wbin  <= '0;
            wgray <= '0;
            rq1   <= '0;
            rq2   <= '0;
        end else begin
            rq1 <= rgray;
            rq2 <= rq1;
            if (wrreq && !wrfull) begin
                wbin  <= wbin_next;
                wgray <= wbin_next ^ (wbin_next >> 1);
            end
        end
    end

    // Read pointer and write-pointer synchroniser
    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
        end else begin
            wq1 <= wgray;
            wq2 <= wq1;
            if (rdreq && !rdempty) begin
                rbin  <= rbin_next;
                rgray <= rbin_next ^ (rbin_next >> 1);
            end
        end
    end

    assign wrfull  = (wgray == {~rq2[9:8], rq2[7:0]});
    assign rdempty = (rgray == wq2);
    assign q       = mem[rbin[8:0]];
endmodule

module lockin_result_collector #(
    parameter int IDX_W = 16
) (
    input  logic         clk_50,
    input  logic         reset,
    input  logic         running,
    input  logic         XY_ch_acquire,
    input  logic [31:0]  X_in,
    input  logic [31:0]  Y_in,
    input  logic [79:0]  NCO_ch_parameters,
    input  logic         clr_fifo_cmd,
    input  logic         clk_udp,
    input  logic         result_rd_udp,
    output logic [127:0] result_data_udp,
    output logic         result_empty_udp,
    output logic         overflow,
    output logic [15:0]  dropped_count
);
    typedef enum logic [1:0] {IDLE, ARMED, WRITE, HOLD} state_t;

    state_t       state, next_state;
    logic         running_d, rise;
    logic         wrreq, wrfull, capture, drop, restart;
    logic [IDX_W-1:0] sample_idx;
    logic [127:0] hold_word, new_word;
    logic [15:0]  low_field;

    assign rise = running & ~running_d;

`ifdef LOCKIN_RESULT_TIMESTAMP_EN
    logic [31:0] timestamp;

    // Run timestamp, restarted on every rising edge of running
    always_ff @(posedge clk_50) begin
        if (reset || rise)
            timestamp <= '0;
        else
            timestamp <= timestamp + 32'd1;
    end

    assign low_field = timestamp[15:0];
`else
    assign low_field = NCO_ch_parameters[15:0];
`endif

    assign new_word = {NCO_ch_parameters[79:48] + NCO_ch_parameters[47:16],
                       X_in, Y_in, 16'(sample_idx), low_field};

    // Registered copy of running for edge detection
    always_ff @(posedge clk_50) begin
        if (reset)
            running_d <= 1'b0;
        else
            running_d <= running;
    end

    // FSM state register
    always_ff @(posedge clk_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state, write request and capture/drop decisions
    always_comb begin
        next_state = state;
        wrreq      = 1'b0;
        capture    = 1'b0;
        drop       = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    restart    = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (XY_ch_acquire && running) begin
                    capture    = 1'b1;
                    next_state = WRITE;
                end else if (!running) begin
                    next_state = IDLE;
                end
            end
            WRITE, HOLD: begin
                drop = XY_ch_acquire & running;
                if (!wrfull) begin
                    wrreq      = 1'b1;
                    next_state = running ? ARMED : IDLE;
                end else begin
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
        // Clear wins over everything, including a coincident strobe
        if (reset || clr_fifo_cmd) begin
            next_state = IDLE;
            wrreq      = 1'b0;
            capture    = 1'b0;
            drop       = 1'b0;
            restart    = 1'b0;
        end
    end

    // Hold register, sample index and drop statistics
    always_ff @(posedge clk_50) begin
        if (reset || clr_fifo_cmd) begin
            hold_word     <= '0;
            sample_idx    <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (restart)
                sample_idx <= '0;
            if (capture) begin
                hold_word  <= new_word;
                sample_idx <= sample_idx + 1'b1;
            end
            if (drop) begin
                sample_idx <= sample_idx + 1'b1;
                overflow   <= 1'b1;
                if (dropped_count != 16'hFFFF)
                    dropped_count <= dropped_count + 16'd1;
            end
        end
    end

    result_fifo u_result_fifo (
        .aclr    (reset | clr_fifo_cmd),
        .wrclk   (clk_50),
        .wrreq   (wrreq),
        .data    (hold_word),
        .wrfull  (wrfull),
        .rdclk   (clk_udp),
        .rdreq   (result_rd_udp),
        .q       (result_data_udp),
        .rdempty (result_empty_udp)
    );
endmodule

// File: tb/tb_lockin_result_collector.sv
// Scoreboard bench for lockin_result_collector: the stimulus side predicts
// every result word from the capture rules and queues it; a monitor in the
// clk_udp domain pops and compares each word the FIFO presents.
module tb_lockin_result_collector;
    logic         clk_50 = 1'b0;
    logic         clk_udp = 1'b0;
    logic         reset = 1'b1;
    logic         running = 1'b0;
    logic         XY_ch_acquire = 1'b0;
    logic [31:0]  X_in = '0;
    logic [31:0]  Y_in = '0;
    logic [79:0]  NCO_ch_parameters = '0;
    logic         clr_fifo_cmd = 1'b0;
    logic         result_rd_udp = 1'b0;
    logic [127:0] result_data_udp;
    logic         result_empty_udp;
    logic         overflow;
    logic [15:0]  dropped_count;

    lockin_result_collector #(.IDX_W(16)) dut (
        .clk_50            (clk_50),
        .reset             (reset),
        .running           (running),
        .XY_ch_acquire     (XY_ch_acquire),
        .X_in              (X_in),
        .Y_in              (Y_in),
        .NCO_ch_parameters (NCO_ch_parameters),
        .clr_fifo_cmd      (clr_fifo_cmd),
        .clk_udp           (clk_udp),
        .result_rd_udp     (result_rd_udp),
        .result_data_udp   (result_data_udp),
        .result_empty_udp  (result_empty_udp),
        .overflow          (overflow),
        .dropped_count     (dropped_count)
    );

    always #10 clk_50 = ~clk_50;
    always #7  clk_udp = ~clk_udp;

    localparam longint NEVER = 64'h7FFF_FFFF_FFFF_FFFF;

    int checks = 0;
    int errors = 0;
    int rd_budget = 0;
    longint cyc = 0;

    logic [127:0] exp_q [$];

    // stimulus values applied on the next step
    logic [31:0] s_x, s_y, s_fi, s_fm;
    logic [15:0] s_amp;

    // reference model state
    logic [15:0] m_idx = '0;
    logic [15:0] m_drops = '0;
    logic        m_ovf = 1'b0;
    logic        m_blocked = 1'b0;
    longint      m_armed_from = NEVER;
    longint      m_last_acc = -10;
    longint      m_rise = 0;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_word(input logic [15:0] idx, input longint c);
        logic [15:0] low;
`ifdef LOCKIN_RESULT_TIMESTAMP_EN
        low = 16'(c - m_rise - 1);
`else
        low = s_amp;
`endif
        return {s_fi + s_fm, s_x, s_y, idx, low};
    endfunction

    // One clk_50 cycle of stimulus, with the model updated for that cycle
    task automatic step(input bit stb, input bit run_v, input bit clr);
        @(posedge clk_50);
        #1;
        if (run_v && !running) begin
            m_rise       = cyc;
            m_armed_from = cyc + 1;
            m_idx        = '0;
        end
        running           = run_v;
        XY_ch_acquire     = stb;
        clr_fifo_cmd      = clr;
        X_in              = s_x;
        Y_in              = s_y;
        NCO_ch_parameters = {s_fi, s_fm, s_amp};
        if (clr) begin
            m_idx        = '0;
            m_drops      = '0;
            m_ovf        = 1'b0;
            m_blocked    = 1'b0;
            m_armed_from = NEVER;
        end else if (stb && run_v && cyc >= m_armed_from) begin
            if (m_blocked || cyc < m_last_acc + 2) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else begin
                exp_q.push_back(model_word(m_idx, cyc));
                m_last_acc = cyc;
            end
            m_idx = m_idx + 16'd1;
        end
    endtask

    task automatic idle(input int n, input bit run_v);
        for (int i = 0; i < n; i++) step(1'b0, run_v, 1'b0);
    endtask

    task automatic randomize_inputs();
        s_x   = $urandom;
        s_y   = $urandom;
        s_fi  = $urandom;
        s_fm  = $urandom;
        s_amp = 16'($urandom);
    endtask

    task automatic check_status(input string tag);
        @(negedge clk_50);
        chk({tag, "_overflow"}, 128'(overflow), 128'(m_ovf));
        chk({tag, "_dropped"}, 128'(dropped_count), 128'(m_drops));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 6000 && exp_q.size() > 0; i++) @(posedge clk_50);
        repeat (4) @(posedge clk_50);
        chk({tag, "_pending_words"}, 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: consume and compare each word the FIFO presents
    always @(negedge clk_udp) begin
        logic [127:0] w;
        result_rd_udp = 1'b0;
        if (rd_budget > 0 && !reset && !clr_fifo_cmd && result_empty_udp === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word got %h want none", result_data_udp);
            end else begin
                w = exp_q.pop_front();
                chk("result_word", result_data_udp, w);
            end
            result_rd_udp = 1'b1;
            rd_budget--;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_x = '0; s_y = '0; s_fi = '0; s_fm = '0; s_amp = '0;
        repeat (3) @(posedge clk_50);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk_udp);
        chk("reset_empty", 128'(result_empty_udp), 128'(1));
        check_status("reset");
        rd_budget = 1000000;

        // lossless capture with the documented values
        idle(3, 1'b1);
        s_fi = 32'h1000_0000; s_amp = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            s_x  = 32'(k + 1);
            s_y  = -s_x;
            s_fm = 32'(k * 16);
            step(1'b1, 1'b1, 1'b0);
            idle(99, 1'b1);
        end
        wait_drain("lossless");
        check_status("lossless");

        // back-to-back strobes: second one dropped, index gap of two
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        wait_drain("b2b");
        check_status("b2b");

        // idle strobe, then run restart
        idle(4, 1'b0);
        randomize_inputs();
        step(1'b1, 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("idle_strobe_empty", 128'(result_empty_udp), 128'(1));
        chk("idle_strobe_queue", 128'(exp_q.size()), 128'(0));
        idle(5, 1'b1);
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        wait_drain("restart");

        // randomized strobe pattern with occasional collisions
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step($urandom_range(0, 2) == 0, 1'b1, 1'b0);
        end
        idle(3, 1'b1);
        wait_drain("random");
        check_status("random");

        // clear coincident with a strobe
        randomize_inputs();
        step(1'b1, 1'b1, 1'b1);
        idle(10, 1'b1);
        @(negedge clk_udp);
        chk("clear_empty", 128'(result_empty_udp), 128'(1));
        check_status("clear");
        idle(4, 1'b0);

        // full FIFO: hold, drop, single read, resume
        rd_budget = 0;
        idle(2, 1'b1);
        for (int k = 0; k < 512; k++) begin
            randomize_inputs();
            step(1'b1, 1'b1, 1'b0);
            idle(2, 1'b1);
        end
        idle(4, 1'b1);
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        m_blocked = 1'b1;
        idle(4, 1'b1);
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_status("full_drop");
        rd_budget = 1;
        idle(20, 1'b1);
        m_blocked = 1'b0;
        randomize_inputs();
        step(1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        rd_budget = 1000000;
        wait_drain("full");

        // reset while holding a word against a full FIFO
        rd_budget = 0;
        for (int k = 0; k < 513; k++) begin
            randomize_inputs();
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        idle(3, 1'b1);
        @(posedge clk_50);
        #1;
        reset = 1'b1;
        running = 1'b0;
        repeat (2) @(posedge clk_50);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_idx = '0; m_drops = '0; m_ovf = 1'b0; m_blocked = 1'b0;
        m_armed_from = NEVER;
        rd_budget = 1000000;
        idle(40, 1'b0);
        @(negedge clk_udp);
        chk("reset_hold_empty", 128'(result_empty_udp), 128'(1));
        check_status("reset_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
